// File: rtl/fb_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_access_arbiter_if
//   Bundles every non-clock/reset signal of the frame-buffer arbiter.
//   slave  : arbiter view (requests and RAM read data in; grants, read
//            results, clear status and RAM command out).
//   master : requester/RAM side view (the mirror image).
//   Groups: vblank/clear_*   frame-clear control
//           scan_*           scanout read port
//           wr0_* / wr1_*    game-logic and overlay write ports
//           mem_*            single-port frame-buffer RAM command/data
// ---------------------------------------------------------------------------
interface fb_access_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic              vblank;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;

  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_rvalid;

  logic              wr0_valid;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr0_ready;

  logic              wr1_valid;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr1_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vblank, clear_req,
    input  scan_req, scan_addr,
    input  wr0_valid, wr0_addr, wr0_data,
    input  wr1_valid, wr1_addr, wr1_data,
    input  mem_rdata,
    output clear_busy, clear_done,
    output scan_rdata, scan_rvalid,
    output wr0_ready, wr1_ready,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vblank, clear_req,
    output scan_req, scan_addr,
    output wr0_valid, wr0_addr, wr0_data,
    output wr1_valid, wr1_addr, wr1_data,
    output mem_rdata,
    input  clear_busy, clear_done,
    input  scan_rdata, scan_rvalid,
    input  wr0_ready, wr1_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// fb_access_arbiter
//   Shares one single-port frame-buffer RAM between the VGA scanout reader
//   (absolute priority) and two writers (wr0 game logic, wr1 overlay) that
//   are round-robin arbitrated on the cycles scanout leaves free.
//   Optional frame-clear sequencer, built only when FB_CLEAR_EN is defined:
//   sweeps CLEAR_COLOR over the whole buffer, starting in vertical blanking.
//
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : fb_access_arbiter_if.slave (scan/wr0/wr1/clear/mem signals)
//
// Timing
//   Grants (wrN_ready) are combinational; the RAM command (mem_*) is
//   registered. Scan reads return scan_rvalid/scan_rdata two cycles after
//   scan_req, fully pipelined. Addresses >= DEPTH never reach the RAM;
//   such writes are still acknowledged and such reads return zero.
// ---------------------------------------------------------------------------
module fb_access_arbiter #(
  parameter int                ADDR_W      = 15,
  parameter int                DATA_W      = 12,
  parameter int                DEPTH       = 19200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = 12'h000
) (
  input logic               clk,
  input logic               reset,
  fb_access_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic scan_in_range;
  logic wr0_in_range;
  logic wr1_in_range;

  assign scan_in_range = (bus.scan_addr <= LAST_ADDR);
  assign wr0_in_range  = (bus.wr0_addr  <= LAST_ADDR);
  assign wr1_in_range  = (bus.wr1_addr  <= LAST_ADDR);

  // ------------------------------------------------------------------------
  // Frame-clear sequencer
  // ------------------------------------------------------------------------
  logic              in_clear;
  logic [ADDR_W-1:0] clr_addr;

`ifdef FB_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_reg;
  logic              pending_reg;
  logic              clear_done_reg;
  logic [ADDR_W-1:0] clr_addr_reg;

  assign in_clear = (state_reg == S_CLEAR);
  assign clr_addr = clr_addr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      pending_reg    <= 1'b0;
      clear_done_reg <= 1'b0;
      clr_addr_reg   <= '0;
    end else begin
      clear_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // A request outside blanking is parked until vblank arrives.
          if ((bus.clear_req || pending_reg) && bus.vblank) begin
            state_reg    <= S_CLEAR;
            pending_reg  <= 1'b0;
            clr_addr_reg <= '0;
          end else if (bus.clear_req) begin
            pending_reg <= 1'b1;
          end
        end
        S_CLEAR: begin
          // Scanout steals the port; the sweep simply resumes next cycle.
          // vblank is not consulted here: a started clear always finishes.
          if (!bus.scan_req) begin
            clr_addr_reg <= clr_addr_reg + 1'b1;
            if (clr_addr_reg == LAST_ADDR) begin
              state_reg      <= S_IDLE;
              clear_done_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.clear_busy = pending_reg | in_clear;
  assign bus.clear_done = clear_done_reg;
`else
  wire unused_clear_inputs = bus.clear_req | bus.vblank;

  assign in_clear       = 1'b0;
  assign clr_addr       = '0;
  assign bus.clear_busy = 1'b0;
  assign bus.clear_done = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Arbitration (combinational)
  // rr_last_reg holds the index of the most recent writer winner; a tie goes
  // to the other writer. Reset value 1 lets wr0 win the first tie.
  // ------------------------------------------------------------------------
  logic rr_last_reg;
  logic gnt0;
  logic gnt1;
  logic clr_wr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!bus.scan_req && !in_clear) begin
      if (bus.wr0_valid && bus.wr1_valid) begin
        gnt0 = rr_last_reg;
        gnt1 = !rr_last_reg;
      end else begin
        gnt0 = bus.wr0_valid;
        gnt1 = bus.wr1_valid;
      end
    end
  end

  assign clr_wr = in_clear && !bus.scan_req;

  // Gate with reset so every output reads 0 while reset is held.
  assign bus.wr0_ready = gnt0 & reset;
  assign bus.wr1_ready = gnt1 & reset;

  // ------------------------------------------------------------------------
  // RAM command and scan read-return pipeline
  // Stage 1: command issued (mem_* registered).
  // Stage 2: RAM output register holds the word.
  // Stage 3: word captured into scan_rdata with scan_rvalid.
  // ------------------------------------------------------------------------
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              rd_v1_reg;
  logic              rd_v2_reg;
  logic              rd_oor1_reg;
  logic              rd_oor2_reg;
  logic              scan_rvalid_reg;
  logic [DATA_W-1:0] scan_rdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      rr_last_reg     <= 1'b1;
      rd_v1_reg       <= 1'b0;
      rd_v2_reg       <= 1'b0;
      rd_oor1_reg     <= 1'b0;
      rd_oor2_reg     <= 1'b0;
      scan_rvalid_reg <= 1'b0;
      scan_rdata_reg  <= '0;
    end else begin
      mem_en_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;

      rd_v1_reg       <= bus.scan_req;
      rd_oor1_reg     <= !scan_in_range;
      rd_v2_reg       <= rd_v1_reg;
      rd_oor2_reg     <= rd_oor1_reg;
      scan_rvalid_reg <= rd_v2_reg;
      if (rd_v2_reg) begin
        scan_rdata_reg <= rd_oor2_reg ? '0 : bus.mem_rdata;
      end

      if (bus.scan_req) begin
        mem_en_reg   <= scan_in_range;
        mem_addr_reg <= bus.scan_addr;
      end else if (clr_wr) begin
        mem_en_reg    <= 1'b1;
        mem_we_reg    <= 1'b1;
        mem_addr_reg  <= clr_addr;
        mem_wdata_reg <= CLEAR_COLOR;
      end else if (gnt0) begin
        mem_en_reg    <= wr0_in_range;
        mem_we_reg    <= wr0_in_range;
        mem_addr_reg  <= bus.wr0_addr;
        mem_wdata_reg <= bus.wr0_data;
        rr_last_reg   <= 1'b0;
      end else if (gnt1) begin
        mem_en_reg    <= wr1_in_range;
        mem_we_reg    <= wr1_in_range;
        mem_addr_reg  <= bus.wr1_addr;
        mem_wdata_reg <= bus.wr1_data;
        rr_last_reg   <= 1'b1;
      end
    end
  end

  assign bus.mem_en      = mem_en_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.scan_rvalid = scan_rvalid_reg;
  assign bus.scan_rdata  = scan_rdata_reg;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_access_arbiter
//   Directed bench for fb_access_arbiter with a behavioural single-port RAM
//   (registered read). Clear-sequencer scenarios are compiled only when
//   FB_CLEAR_EN is defined; otherwise the disabled behaviour is exercised.
// ---------------------------------------------------------------------------
module tb_fb_access_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 19200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CLEAR_COLOR(12'h000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:DEPTH-1];

  always @(posedge clk) begin
    if (bus.mem_en && (bus.mem_addr < 15'(DEPTH))) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.scan_req  = 1'b0;
    bus.wr0_valid = 1'b0;
    bus.wr1_valid = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic test_reset();
    bus.vblank = 1'b0; bus.clear_req = 1'b0; bus.scan_req = 1'b0;
    bus.scan_addr = '0; bus.wr1_valid = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.wr0_valid = 1'b1; bus.wr0_addr = 15'd1; bus.wr0_data = 12'hFFF;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr0_ready got %0b want 0", bus.wr0_ready); end
    n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %0b want 0", bus.mem_en); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0b want 0", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 15'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 12'd0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
    n_checks++; if (bus.scan_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_scan_rvalid got %0b want 0", bus.scan_rvalid); end
    n_checks++; if (bus.scan_rdata !== 12'd0) begin n_fail++; $display("FAIL reset_scan_rdata got %h want 0", bus.scan_rdata); end
    n_checks++; if (bus.clear_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clear_busy got %0b want 0", bus.clear_busy); end
    n_checks++; if (bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_clear_done got %0b want 0", bus.clear_done); end
    idle_inputs();
    reset = 1'b1;
    tick();
    $display("test_reset: reset released");
  endtask

  task automatic test_contention();
    // cycle A: scan + both writers -> read wins
    bus.scan_req = 1'b1; bus.scan_addr = 15'd7;
    bus.wr0_valid = 1'b1; bus.wr0_addr = 15'd5; bus.wr0_data = 12'hABC;
    bus.wr1_valid = 1'b1; bus.wr1_addr = 15'd6; bus.wr1_data = 12'h123;
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b0 || bus.wr1_ready !== 1'b0) begin n_fail++; $display("FAIL cont_scan_blocks got r0=%0b r1=%0b want 0 0", bus.wr0_ready, bus.wr1_ready); end
    tick();
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 15'd7) begin n_fail++; $display("FAIL cont_read_cmd got en=%0b we=%0b a=%0d want 1 0 7", bus.mem_en, bus.mem_we, bus.mem_addr); end
    $display("contention: read addr 7 issued");
    // cycle B: wr0 wins the first tie
    bus.scan_req = 1'b0;
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b1 || bus.wr1_ready !== 1'b0) begin n_fail++; $display("FAIL cont_first_tie got r0=%0b r1=%0b want 1 0", bus.wr0_ready, bus.wr1_ready); end
    tick();
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd5 || bus.mem_wdata !== 12'hABC) begin n_fail++; $display("FAIL cont_wr0_cmd got we=%0b a=%0d d=%h want 1 5 abc", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    $display("contention: wr0 write addr 5 data abc");
    // cycle C: wr0 presents a new write, tie now goes to wr1
    bus.wr0_addr = 15'd8; bus.wr0_data = 12'h0F0;
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b0 || bus.wr1_ready !== 1'b1) begin n_fail++; $display("FAIL cont_second_tie got r0=%0b r1=%0b want 0 1", bus.wr0_ready, bus.wr1_ready); end
    tick();
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd6 || bus.mem_wdata !== 12'h123) begin n_fail++; $display("FAIL cont_wr1_cmd got we=%0b a=%0d d=%h want 1 6 123", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    $display("contention: wr1 write addr 6 data 123");
    // cycle D: wr0 alone
    bus.wr1_valid = 1'b0;
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b1) begin n_fail++; $display("FAIL cont_wr0_alone got %0b want 1", bus.wr0_ready); end
    tick();
    n_checks++; if (bus.mem_addr !== 15'd8 || bus.mem_wdata !== 12'h0F0) begin n_fail++; $display("FAIL cont_wr0_alone_cmd got a=%0d d=%h want 8 0f0", bus.mem_addr, bus.mem_wdata); end
    $display("contention: wr0 write addr 8 data 0f0");
    idle_inputs();
  endtask

  task automatic test_fairness();
    logic [ADDR_W-1:0] a0, a1, exp_a;
    logic [DATA_W-1:0] exp_d;
    logic              exp1;
    int                c0, c1;
    c0 = 0; c1 = 0;
    // last winner was wr0, so wr1 takes the first tie
    for (int i = 0; i < 10; i++) begin
      a0 = 15'(300 + c0); a1 = 15'(400 + c1);
      bus.wr0_valid = 1'b1; bus.wr0_addr = a0; bus.wr0_data = 12'(12'hA00 + c0);
      bus.wr1_valid = 1'b1; bus.wr1_addr = a1; bus.wr1_data = 12'(12'hB00 + c1);
      exp1  = (i % 2 == 0);
      exp_a = exp1 ? a1 : a0;
      exp_d = exp1 ? 12'(12'hB00 + c1) : 12'(12'hA00 + c0);
      #1;
      n_checks++; if (bus.wr0_ready !== !exp1 || bus.wr1_ready !== exp1) begin n_fail++; $display("FAIL fair_grant_%0d got r0=%0b r1=%0b want %0b %0b", i, bus.wr0_ready, bus.wr1_ready, !exp1, exp1); end
      tick();
      n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== exp_a || bus.mem_wdata !== exp_d) begin n_fail++; $display("FAIL fair_cmd_%0d got we=%0b a=%0d d=%h want 1 %0d %h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_a, exp_d); end
      $display("fairness: cycle %0d write addr %0d data %h", i, exp_a, exp_d);
      if (exp1) c1++; else c0++;
    end
    idle_inputs();
  endtask

  task automatic test_scan_single();
    bus.scan_req = 1'b1; bus.scan_addr = 15'd5;
    tick();
    bus.scan_req = 1'b0;
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 15'd5) begin n_fail++; $display("FAIL scan_cmd got en=%0b we=%0b a=%0d want 1 0 5", bus.mem_en, bus.mem_we, bus.mem_addr); end
    n_checks++; if (bus.scan_rvalid !== 1'b0) begin n_fail++; $display("FAIL scan_early_1 got %0b want 0", bus.scan_rvalid); end
    tick();
    n_checks++; if (bus.scan_rvalid !== 1'b0) begin n_fail++; $display("FAIL scan_early_2 got %0b want 0", bus.scan_rvalid); end
    tick();
    n_checks++; if (bus.scan_rvalid !== 1'b1 || bus.scan_rdata !== 12'hABC) begin n_fail++; $display("FAIL scan_data got v=%0b d=%h want 1 abc", bus.scan_rvalid, bus.scan_rdata); end
    tick();
    n_checks++; if (bus.scan_rvalid !== 1'b0) begin n_fail++; $display("FAIL scan_single_pulse got %0b want 0", bus.scan_rvalid); end
    $display("scan: addr 5 returned %h", 12'hABC);
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4];
    logic [DATA_W-1:0] datas [4];
    addrs[0] = 15'd5;   datas[0] = 12'hABC;
    addrs[1] = 15'd6;   datas[1] = 12'h123;
    addrs[2] = 15'd8;   datas[2] = 12'h0F0;
    addrs[3] = 15'd300; datas[3] = 12'hA00;
    for (int c = 0; c < 7; c++) begin
      bus.scan_req  = (c < 4);
      bus.scan_addr = (c < 4) ? addrs[c] : 15'd0;
      tick();
      if (c >= 2 && c < 6) begin
        n_checks++; if (bus.scan_rvalid !== 1'b1 || bus.scan_rdata !== datas[c-2]) begin n_fail++; $display("FAIL b2b_read_%0d got v=%0b d=%h want 1 %h", c - 2, bus.scan_rvalid, bus.scan_rdata, datas[c-2]); end
        $display("back_to_back: read %0d addr %0d data %h", c - 2, addrs[c-2], datas[c-2]);
      end else begin
        n_checks++; if (bus.scan_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d got %0b want 0", c, bus.scan_rvalid); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    bus.wr0_valid = 1'b1; bus.wr0_addr = 15'd19200; bus.wr0_data = 12'h555;
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ready got %0b want 1", bus.wr0_ready); end
    tick();
    n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_wr_cmd got en=%0b we=%0b want 0 0", bus.mem_en, bus.mem_we); end
    $display("out_of_range: write addr 19200 dropped");
    bus.wr0_valid = 1'b0;
    bus.scan_req = 1'b1; bus.scan_addr = 15'd19201;
    tick();
    bus.scan_req = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.scan_rvalid !== 1'b1 || bus.scan_rdata !== 12'h000) begin n_fail++; $display("FAIL oor_read got v=%0b d=%h want 1 000", bus.scan_rvalid, bus.scan_rdata); end
    $display("out_of_range: read addr 19201 returned 000");
  endtask

  task automatic test_idle_hold();
    bus.wr1_valid = 1'b1; bus.wr1_addr = 15'd10; bus.wr1_data = 12'h777;
    #1;
    n_checks++; if (bus.wr1_ready !== 1'b1) begin n_fail++; $display("FAIL idle_wr1_ready got %0b want 1", bus.wr1_ready); end
    tick();
    bus.wr1_valid = 1'b0;
    tick();
    n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 15'd10 || bus.mem_wdata !== 12'h777) begin n_fail++; $display("FAIL idle_hold got en=%0b we=%0b a=%0d d=%h want 0 0 10 777", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    $display("idle: command held at addr 10 data 777");
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int   n, scans;
    logic done, saw_ready;
    logic [ADDR_W-1:0] raddr [3];
    raddr[0] = 15'd0; raddr[1] = 15'd5; raddr[2] = 15'd19199;
    bus.vblank = 1'b0; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    n_checks++; if (bus.clear_busy !== 1'b1) begin n_fail++; $display("FAIL clear_pending_busy got %0b want 1", bus.clear_busy); end
    repeat (3) tick();
    n_checks++; if (bus.mem_en !== 1'b0 || bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL clear_pending_quiet got en=%0b done=%0b want 0 0", bus.mem_en, bus.clear_done); end
    $display("clear: pending outside vblank");
    bus.vblank = 1'b1;
    tick();
    bus.wr0_valid = 1'b1; bus.wr0_addr = 15'd20; bus.wr0_data = 12'h3FF;
    n = 0; scans = 0; done = 1'b0; saw_ready = 1'b0;
    while (!done && n < 30000) begin
      bus.scan_req  = (n % 4 == 3);
      bus.scan_addr = 15'd5;
      if (n == 50) bus.vblank = 1'b0;
      #1;
      if (bus.wr0_ready) saw_ready = 1'b1;
      if (bus.scan_req) scans++;
      tick();
      if (n == 0) begin
        n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd0 || bus.mem_wdata !== 12'h000 || bus.clear_busy !== 1'b1) begin n_fail++; $display("FAIL clear_first_write got en=%0b we=%0b a=%0d d=%h busy=%0b want 1 1 0 000 1", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.clear_busy); end
      end
      if (bus.clear_done) done = 1'b1;
      n++;
    end
    bus.scan_req = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clear_timeout got done=%0b want 1", done); end
    n_checks++; if (n != DEPTH + scans) begin n_fail++; $display("FAIL clear_cycles got %0d want %0d", n, DEPTH + scans); end
    n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL clear_wr0_blocked got %0b want 0", saw_ready); end
    $display("clear: sweep took %0d cycles with %0d scan reads", n, scans);
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b1 || bus.clear_busy !== 1'b0) begin n_fail++; $display("FAIL clear_after_release got r0=%0b busy=%0b want 1 0", bus.wr0_ready, bus.clear_busy); end
    tick();
    n_checks++; if (bus.clear_done !== 1'b0 || bus.mem_addr !== 15'd20) begin n_fail++; $display("FAIL clear_done_pulse got done=%0b a=%0d want 0 20", bus.clear_done, bus.mem_addr); end
    bus.wr0_valid = 1'b0;
    repeat (3) tick();
    for (int c = 0; c < 5; c++) begin
      bus.scan_req  = (c < 3);
      bus.scan_addr = (c < 3) ? raddr[c] : 15'd0;
      tick();
      if (c >= 2) begin
        n_checks++; if (bus.scan_rvalid !== 1'b1 || bus.scan_rdata !== 12'h000) begin n_fail++; $display("FAIL clear_readback_%0d got v=%0b d=%h want 1 000", raddr[c-2], bus.scan_rvalid, bus.scan_rdata); end
        $display("clear: readback addr %0d", raddr[c-2]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    logic saw_done;
    bus.vblank = 1'b1; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (100) tick();
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd99) begin n_fail++; $display("FAIL midclr_progress got we=%0b a=%0d want 1 99", bus.mem_we, bus.mem_addr); end
    bus.wr0_valid = 1'b1; bus.wr0_addr = 15'd30; bus.wr0_data = 12'h246;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 15'd0 || bus.wr0_ready !== 1'b0) begin n_fail++; $display("FAIL midclr_reset_outputs got en=%0b we=%0b a=%0d r0=%0b want 0 0 0 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.wr0_ready); end
    n_checks++; if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL midclr_reset_status got busy=%0b done=%0b want 0 0", bus.clear_busy, bus.clear_done); end
    tick();
    reset = 1'b1;
    bus.vblank = 1'b0;
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b1 || bus.clear_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_after got r0=%0b busy=%0b want 1 0", bus.wr0_ready, bus.clear_busy); end
    tick();
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd30) begin n_fail++; $display("FAIL midclr_wr0_cmd got we=%0b a=%0d want 1 30", bus.mem_we, bus.mem_addr); end
    bus.wr0_valid = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin tick(); if (bus.clear_done) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midclr_no_done got %0b want 0", saw_done); end
    $display("reset_mid_clear: aborted at clr_addr 100, wr0 write addr 30");
  endtask
`else
  task automatic test_clear_disabled();
    bus.vblank = 1'b1; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    n_checks++; if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin n_fail++; $display("FAIL nclr_status got busy=%0b done=%0b want 0 0", bus.clear_busy, bus.clear_done); end
    bus.wr0_valid = 1'b1; bus.wr0_addr = 15'd40; bus.wr0_data = 12'h111;
    #1;
    n_checks++; if (bus.wr0_ready !== 1'b1) begin n_fail++; $display("FAIL nclr_wr0_ready got %0b want 1", bus.wr0_ready); end
    tick();
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd40) begin n_fail++; $display("FAIL nclr_wr0_cmd got we=%0b a=%0d want 1 40", bus.mem_we, bus.mem_addr); end
    bus.wr0_valid = 1'b0;
    tick();
    n_checks++; if (bus.mem_en !== 1'b0 || bus.clear_busy !== 1'b0) begin n_fail++; $display("FAIL nclr_no_sweep got en=%0b busy=%0b want 0 0", bus.mem_en, bus.clear_busy); end
    bus.vblank = 1'b0;
    $display("clear_disabled: clear_req ignored, wr0 write addr 40");
  endtask

  task automatic test_reset_midflight();
    bus.wr0_valid = 1'b1; bus.wr0_addr = 15'd50; bus.wr0_data = 12'h222;
    tick();
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 15'd50) begin n_fail++; $display("FAIL midfl_cmd got en=%0b a=%0d want 1 50", bus.mem_en, bus.mem_addr); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_addr !== 15'd0 || bus.wr0_ready !== 1'b0) begin n_fail++; $display("FAIL midfl_reset got en=%0b a=%0d r0=%0b want 0 0 0", bus.mem_en, bus.mem_addr, bus.wr0_ready); end
    tick();
    reset = 1'b1;
    bus.wr0_valid = 1'b0;
    tick();
    $display("reset_midflight: outputs cleared");
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_fairness();
    test_scan_single();
    test_back_to_back();
    test_out_of_range();
    test_idle_hold();
`ifdef FB_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clear_disabled();
    test_reset_midflight();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares one single-port frame-buffer RAM between three requesters:
  - the VGA scanout reader,
  - a game-logic writer (wr0),
  - a sprite/overlay writer (wr1).
- Scanout has absolute priority. The two writers are round-robin arbitrated on cycles left over by scanout.
- Contains a frame-clear sequencer that sweeps the buffer with a constant colour during vertical blanking.
- Sits between the VGA timing/pixel pipeline and the frame-buffer BRAM.

Parameters:
- ADDR_W, 15, frame-buffer address width.
- DATA_W, 12, pixel width (RGB444).
- DEPTH, 19200, number of valid pixel words (160x120).
- CLEAR_COLOR, 12'h000, value written by the clear sequencer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- vblank  in  1  high while the timing generator is in vertical blanking.
- scan_req  in  1  scanout read request (single cycle).
- scan_addr  in  ADDR_W  scanout read address.
- scan_rdata  out  DATA_W  scanout read data.
- scan_rvalid  out  1  scan_rdata valid strobe.
- wr0_valid  in  1  game-logic write request.
- wr0_addr  in  ADDR_W  game-logic write address.
- wr0_data  in  DATA_W  game-logic write data.
- wr0_ready  out  1  wr0 accepted this cycle.
- wr1_valid  in  1  overlay write request.
- wr1_addr  in  ADDR_W  overlay write address.
- wr1_data  in  DATA_W  overlay write data.
- wr1_ready  out  1  wr1 accepted this cycle.
- clear_req  in  1  request a full-buffer clear (pulse).
- clear_busy  out  1  clear pending or in progress.
- clear_done  out  1  one-cycle pulse when the clear completes.
- mem_en  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data (1-cycle registered-output RAM).

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, FSM = S_IDLE, clear pending flag = 0, rr_last = 1 (so wr0 wins the first tie).
- Grants are combinational from the current inputs. mem_* are registered on the next clk edge.
- Priority in S_IDLE:
  - scan_req → read.
  - else wr0/wr1 round-robin: if both valid, grant the one opposite rr_last; if one is valid, grant it. rr_last is updated only on a writer grant.
- wrN_ready = 1 only in the cycle that writer is granted. A writer holds valid/addr/data until it sees ready.
- Read latency:
  - scan_req sampled at edge k drives mem_en=1, mem_we=0 at edge k.
  - mem_rdata is valid after edge k+1.
  - scan_rvalid is high and scan_rdata is registered at edge k+2, so total latency is 2 cycles, fully pipelined (back-to-back scan_req gives back-to-back rvalid).
- Out-of-range addresses (addr ≥ DEPTH):
  - Writes are accepted (ready=1) but mem_we=0 and mem_en=0.
  - Scan reads still produce scan_rvalid with scan_rdata = 0.
- Idle cycle (no request): mem_en=0, mem_we=0; mem_addr and mem_wdata hold their values.
- FSM states:
  - S_IDLE:
    - clear_req and vblank → S_CLEAR with clr_addr = 0.
    - clear_req and !vblank → set pending. Pending and vblank → S_CLEAR.
  - S_CLEAR:
    - Both writers are blocked (ready=0); scan_req still preempts.
    - On each cycle without scan_req, write CLEAR_COLOR at clr_addr, then clr_addr+1.
    - After the write at DEPTH-1 is issued → S_IDLE, clear_done pulses for 1 cycle, pending = 0.
    - A clear that has started continues even if vblank falls.
- clear_req while clear_busy is high is ignored.
- clear_busy = pending OR (state == S_CLEAR).
- Reset asserted mid-clear aborts immediately: state S_IDLE, pending cleared, no clear_done.

Optional Feature:
- Macro FB_CLEAR_EN.
- Defined: clear sequencer present as described.
- Undefined:
  - S_CLEAR and the pending logic are not built.
  - clear_req is ignored.
  - clear_busy and clear_done are tied to 0.
  - Arbitration is otherwise identical.

Test Plan:
- Scan only: scan_req with addr 5, RAM holds 12'hABC at 5 → scan_rvalid high exactly 2 cycles later with scan_rdata = 12'hABC. Four back-to-back requests → four consecutive rvalids in order.
- Contention: wr0_valid, wr1_valid and scan_req all high for 1 cycle → read issued, both ready=0. Next cycle with scan_req low → wr0_ready=1 (rr_last=1 after reset). Following cycle → wr1_ready=1.
- Fairness: wr0 and wr1 valid continuously for 10 cycles, no scan → grants alternate wr0,wr1,…, 5 each. mem_we=1 every cycle with the matching addr/data.
- Out of range: wr0 with addr 19200 → wr0_ready=1, mem_we=0. scan_req at 19201 → scan_rvalid with scan_rdata=0.
- Clear: clear_req with vblank=0 → clear_busy=1, no writes. vblank rises → sweep with interleaved scan_req every 4th cycle. Completes in 19200 + (number of scan cycles) cycles, clear_done pulses once, wr0 is blocked throughout, and RAM reads 12'h000 at addresses 0 and 19199.
- Reset mid-clear: assert reset at clr_addr=100 → all outputs 0 immediately; after release clear_busy=0, no clear_done, wr0 is granted on its next request.
